// File: rtl/freq_meas_ctrl_if.sv
// Requester/counter-side bundle for the frequency measurement sequencer.
// The master side drives requests, enable and the synchronized count; the slave side is the sequencer.
interface freq_meas_ctrl_if #(
    parameter int NCH = 4,
    parameter int CW  = 32
);
    localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;

    logic            en;
    logic [NCH-1:0]  req;
    logic [NCH-1:0]  ack;
    logic            busy;
    logic [SW-1:0]   sel;
    logic            meas_clr;
    logic            meas_gate;
    logic [CW-1:0]   meas_count;
    logic [31:0]     freq;
    logic            freq_valid;
    logic            ovf;

    modport master (
        output en, req, meas_count,
        input  ack, busy, sel, meas_clr, meas_gate, freq, freq_valid, ovf
    );

    modport slave (
        input  en, req, meas_count,
        output ack, busy, sel, meas_clr, meas_gate, freq, freq_valid, ovf
    );
endinterface

// File: rtl/freq_meas_ctrl.sv
// Round-robin measurement sequencer for a shared frequency counter: grants one channel,
// runs clear/gate/settle on ref_clk, converts the gated count to Hz and acknowledges.
module freq_meas_ctrl #(
    parameter int          NCH       = 4,
    parameter int          GATE_LOG2 = 16,
    parameter int          SETTLE    = 4,
    parameter int unsigned REF_HZ    = 10_000_000,
    parameter int          CW        = 32
) (
    input logic             ref_clk,
    input logic             rst_,
    freq_meas_ctrl_if.slave bus
);
    localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PW = CW + $clog2(REF_HZ + 1);
    localparam int TW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [PW-1:0] SAT_LIMIT = PW'(33'h0_FFFF_FFFF);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_GATE,
        S_SETTLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t               state_q;
    logic [SW-1:0]        ptr_q;
    logic [SW-1:0]        sel_q;
    logic [GATE_LOG2-1:0] gate_cnt_q;
    logic [TW-1:0]        settle_cnt_q;
    logic [NCH-1:0]       ack_q;
    logic                 busy_q;
    logic                 clr_q;
    logic                 gate_q;
    logic [31:0]          freq_q;
    logic                 fv_q;
    logic                 ovf_q;

    logic [SW-1:0]        grant_d;
    logic [SW-1:0]        ptr_d;
    logic [32:0]          calc_d;

    // Lowest requesting index at or above p, wrapping modulo NCH.
    function automatic logic [SW-1:0] rr_pick(input logic [NCH-1:0] r, input logic [SW-1:0] p);
        logic [2*NCH-1:0] dbl;
        logic [NCH-1:0]   rot;
        logic [SW:0]      idx;
        dbl = {r, r};
        rot = NCH'(dbl >> p);
        idx = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (rot[k]) idx = {1'b0, p} + (SW+1)'(k);
        end
        if (idx >= (SW+1)'(NCH)) idx = idx - (SW+1)'(NCH);
        return idx[SW-1:0];
    endfunction

    // {ovf, Hz}: count scaled by REF_HZ over a 2^GATE_LOG2-cycle window, saturated to 32 bits.
    function automatic logic [32:0] to_hz(input logic [CW-1:0] cnt);
        logic [PW-1:0] prod;
        logic [PW-1:0] res;
        prod = PW'(cnt) * PW'(REF_HZ);
        res  = prod >> GATE_LOG2;
        if (res > SAT_LIMIT) return {1'b1, 32'hFFFF_FFFF};
        return {1'b0, res[31:0]};
    endfunction

    always_comb begin
        grant_d = rr_pick(bus.req, ptr_q);
        ptr_d   = (sel_q == SW'(NCH - 1)) ? '0 : sel_q + 1'b1;
        calc_d  = to_hz(bus.meas_count);
    end

    always_ff @(posedge ref_clk or negedge rst_) begin
        if (!rst_) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            sel_q        <= '0;
            gate_cnt_q   <= '0;
            settle_cnt_q <= '0;
            ack_q        <= '0;
            busy_q       <= 1'b0;
            clr_q        <= 1'b0;
            gate_q       <= 1'b0;
            freq_q       <= '0;
            fv_q         <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            ack_q <= '0;
            fv_q  <= 1'b0;
            clr_q <= 1'b0;
            // Losing enable mid-measurement discards it; pointer, sel and result stay put.
            if (!bus.en && (state_q inside {S_CLEAR, S_GATE, S_SETTLE, S_CALC})) begin
                state_q      <= S_IDLE;
                busy_q       <= 1'b0;
                gate_q       <= 1'b0;
                gate_cnt_q   <= '0;
                settle_cnt_q <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.en && (|bus.req)) begin
                            sel_q   <= grant_d;
                            clr_q   <= 1'b1;
                            busy_q  <= 1'b1;
                            state_q <= S_CLEAR;
                        end
                    end
                    S_CLEAR: begin
                        gate_q     <= 1'b1;
                        gate_cnt_q <= '0;
                        state_q    <= S_GATE;
                    end
                    S_GATE: begin
                        if (gate_cnt_q == '1) begin
                            gate_q       <= 1'b0;
                            gate_cnt_q   <= '0;
                            settle_cnt_q <= '0;
                            state_q      <= S_SETTLE;
                        end else begin
                            gate_cnt_q <= gate_cnt_q + 1'b1;
                        end
                    end
                    S_SETTLE: begin
                        if (settle_cnt_q == TW'(SETTLE - 1)) begin
                            settle_cnt_q <= '0;
                            state_q      <= S_CALC;
                        end else begin
                            settle_cnt_q <= settle_cnt_q + 1'b1;
                        end
                    end
                    S_CALC: begin
                        {ovf_q, freq_q} <= calc_d;
                        state_q         <= S_DONE;
                    end
                    S_DONE: begin
                        ack_q   <= NCH'(1) << sel_q;
                        fv_q    <= 1'b1;
                        ptr_q   <= ptr_d;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.ack        = ack_q;
    assign bus.busy       = busy_q;
    assign bus.sel        = sel_q;
    assign bus.meas_clr   = clr_q;
    assign bus.meas_gate  = gate_q;
    assign bus.freq       = freq_q;
    assign bus.freq_valid = fv_q;
    assign bus.ovf        = ovf_q;
endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Bench for freq_meas_ctrl: scenario tasks against a round-robin / Hz-conversion reference model.
module tb_freq_meas_ctrl;
    localparam int          NCH       = 4;
    localparam int          GATE_LOG2 = 4;
    localparam int          SETTLE    = 4;
    localparam int unsigned REF_HZ    = 10_000_000;
    localparam int          CW        = 32;
    localparam int          GATE_LEN  = 1 << GATE_LOG2;
    localparam int          ACK_LAT   = 3 + GATE_LEN + SETTLE;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    int   total = 0;
    int   bad = 0;

    int          ptr_m = 0;
    logic [31:0] freq_m = '0;
    logic        ovf_m = 1'b0;

    always #5 clk = ~clk;

    freq_meas_ctrl_if #(.NCH(NCH), .CW(CW)) bus();

    freq_meas_ctrl #(
        .NCH(NCH), .GATE_LOG2(GATE_LOG2), .SETTLE(SETTLE), .REF_HZ(REF_HZ), .CW(CW)
    ) dut (
        .ref_clk(clk),
        .rst_   (rst_b),
        .bus    (bus)
    );

    typedef struct {
        int             ack_cyc;
        logic [NCH-1:0] ack;
        logic [1:0]     sel0;
        logic           busy0;
        logic           clr0;
        int             gate_n;
        bit             sel_ok;
        logic [31:0]    freq;
        logic           ovf;
        logic           fv;
    } obs_t;

    function automatic int pick_m(logic [NCH-1:0] r, int p);
        for (int k = 0; k < NCH; k++) begin
            if (r[(p + k) % NCH]) return (p + k) % NCH;
        end
        return -1;
    endfunction

    function automatic logic [32:0] hz_m(logic [31:0] cnt);
        longint unsigned r;
        r = (64'(cnt) * 64'(REF_HZ)) >> GATE_LOG2;
        if (r > 64'h0000_0000_FFFF_FFFF) return {1'b1, 32'hFFFF_FFFF};
        return {1'b0, r[31:0]};
    endfunction

    function automatic logic [31:0] rand_cnt();
        if ($urandom_range(0, 3) == 0) return $urandom;
        return $urandom_range(0, 10000);
    endfunction

    // Drives one request set through to its ack and records what was seen; count is valid only at the CALC edge.
    task automatic run_meas(input logic [NCH-1:0] reqs, input logic [31:0] cnt, input int drop_at, output obs_t o);
        o.ack_cyc = -1; o.ack = '0; o.gate_n = 0; o.sel_ok = 1'b1;
        o.freq = '0; o.ovf = 1'b0; o.fv = 1'b0;
        bus.en = 1'b1;
        bus.req = reqs;
        bus.meas_count = $urandom;
        @(posedge clk); #1;
        o.sel0 = bus.sel; o.busy0 = bus.busy; o.clr0 = bus.meas_clr;
        for (int c = 1; c <= ACK_LAT + 20; c++) begin
            @(posedge clk); #1;
            if (bus.meas_gate) o.gate_n++;
            if (bus.sel !== o.sel0) o.sel_ok = 1'b0;
            if (bus.ack !== '0) begin
                o.ack_cyc = c; o.ack = bus.ack; o.freq = bus.freq; o.ovf = bus.ovf; o.fv = bus.freq_valid;
                break;
            end
            bus.meas_count = (c == ACK_LAT - 2) ? cnt : $urandom;
            if (c == drop_at) bus.req = '0;
        end
        @(negedge clk);
        bus.req = '0;
        bus.meas_count = $urandom;
    endtask

    task automatic test_reset();
        bus.en = 1'b0; bus.req = '0; bus.meas_count = '0;
        rst_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.ack !== '0) begin bad++; $display("FAIL reset_ack got=%h want=0", bus.ack); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        total++; if (bus.sel !== '0) begin bad++; $display("FAIL reset_sel got=%0d want=0", bus.sel); end
        total++; if ({bus.meas_clr, bus.meas_gate} !== 2'b00) begin bad++; $display("FAIL reset_clr_gate got=%b want=00", {bus.meas_clr, bus.meas_gate}); end
        total++; if (bus.freq !== '0) begin bad++; $display("FAIL reset_freq got=%0d want=0", bus.freq); end
        total++; if ({bus.freq_valid, bus.ovf} !== 2'b00) begin bad++; $display("FAIL reset_fv_ovf got=%b want=00", {bus.freq_valid, bus.ovf}); end
        @(negedge clk);
        rst_b = 1'b1;
        bus.req = 4'hF;
        @(posedge clk); #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL idle_en_low_busy got=%b want=0", bus.busy); end
        @(negedge clk);
        bus.req = '0;
        ptr_m = 0; freq_m = '0; ovf_m = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [NCH-1:0] masks [6] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h9, 4'h9};
        int             order [6] = '{0, 1, 2, 3, 0, 3};
        obs_t           o;
        logic [31:0]    cnt;
        for (int i = 0; i < 6; i++) begin
            cnt = rand_cnt();
            run_meas(masks[i], cnt, 0, o);
            {ovf_m, freq_m} = hz_m(cnt);
            total++; if (int'(o.sel0) !== order[i]) begin bad++; $display("FAIL rr_sel[%0d] got=%0d want=%0d", i, o.sel0, order[i]); end
            total++; if (o.ack_cyc !== ACK_LAT || o.ack !== NCH'(1 << order[i])) begin
                bad++; $display("FAIL rr_ack[%0d] got=%h@%0d want=%h@%0d", i, o.ack, o.ack_cyc, NCH'(1 << order[i]), ACK_LAT);
            end
            total++; if ({o.ovf, o.freq} !== {ovf_m, freq_m}) begin bad++; $display("FAIL rr_freq[%0d] got=%b/%0d want=%b/%0d", i, o.ovf, o.freq, ovf_m, freq_m); end
            ptr_m = (order[i] + 1) % NCH;
        end
    endtask

    task automatic test_single();
        obs_t o;
        run_meas(4'b0010, 32'd16, 0, o);
        total++; if (o.sel0 !== 2'd1) begin bad++; $display("FAIL single_sel got=%0d want=1", o.sel0); end
        total++; if ({o.busy0, o.clr0} !== 2'b11) begin bad++; $display("FAIL single_busy_clr got=%b want=11", {o.busy0, o.clr0}); end
        total++; if (o.gate_n !== GATE_LEN) begin bad++; $display("FAIL single_gate_len got=%0d want=%0d", o.gate_n, GATE_LEN); end
        total++; if (o.ack_cyc !== ACK_LAT) begin bad++; $display("FAIL single_ack_lat got=%0d want=%0d", o.ack_cyc, ACK_LAT); end
        total++; if (o.ack !== 4'b0010 || o.fv !== 1'b1) begin bad++; $display("FAIL single_ack got=%b fv=%b want=0010 fv=1", o.ack, o.fv); end
        total++; if (o.freq !== 32'd10_000_000 || o.ovf !== 1'b0) begin bad++; $display("FAIL single_freq got=%0d ovf=%b want=10000000 ovf=0", o.freq, o.ovf); end
        total++; if (!o.sel_ok) begin bad++; $display("FAIL single_sel_stable got=0 want=1"); end
        @(posedge clk); #1;
        total++; if ({bus.ack, bus.freq_valid, bus.busy} !== 6'b0) begin bad++; $display("FAIL single_pulse_end got=%b want=0", {bus.ack, bus.freq_valid, bus.busy}); end
        total++; if (bus.freq !== 32'd10_000_000) begin bad++; $display("FAIL single_freq_hold got=%0d want=10000000", bus.freq); end
        @(negedge clk);
        ptr_m = 2; freq_m = 32'd10_000_000; ovf_m = 1'b0;
    endtask

    task automatic test_saturation();
        obs_t           o;
        logic [NCH-1:0] r;
        int             ch;
        r = NCH'($urandom_range(1, 15));
        ch = pick_m(r, ptr_m);
        run_meas(r, 32'hFFFF_FFFF, 0, o);
        total++; if (o.ack !== NCH'(1 << ch)) begin bad++; $display("FAIL sat_ack got=%b want=%b", o.ack, NCH'(1 << ch)); end
        total++; if (o.freq !== 32'hFFFF_FFFF || o.ovf !== 1'b1) begin bad++; $display("FAIL sat_freq got=%h ovf=%b want=ffffffff ovf=1", o.freq, o.ovf); end
        ptr_m = (ch + 1) % NCH;
        r = NCH'($urandom_range(1, 15));
        ch = pick_m(r, ptr_m);
        run_meas(r, 32'd8, 0, o);
        total++; if (o.ack !== NCH'(1 << ch)) begin bad++; $display("FAIL unsat_ack got=%b want=%b", o.ack, NCH'(1 << ch)); end
        total++; if (o.freq !== 32'd5_000_000 || o.ovf !== 1'b0) begin bad++; $display("FAIL unsat_freq got=%0d ovf=%b want=5000000 ovf=0", o.freq, o.ovf); end
        ptr_m = (ch + 1) % NCH; freq_m = 32'd5_000_000; ovf_m = 1'b0;
    endtask

    task automatic test_abort();
        obs_t           o;
        logic [NCH-1:0] r;
        logic [31:0]    cnt;
        int             ch;
        bit             stray;
        r = NCH'($urandom_range(1, 15));
        ch = pick_m(r, ptr_m);
        bus.en = 1'b1; bus.req = r; bus.meas_count = $urandom;
        @(posedge clk); #1;
        repeat (5) begin @(posedge clk); #1; end
        total++; if (bus.meas_gate !== 1'b1) begin bad++; $display("FAIL abort_pre_gate got=%b want=1", bus.meas_gate); end
        bus.en = 1'b0;
        @(posedge clk); #1;
        total++; if ({bus.busy, bus.meas_gate} !== 2'b00) begin bad++; $display("FAIL abort_idle got=%b want=00", {bus.busy, bus.meas_gate}); end
        stray = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (bus.ack !== '0 || bus.freq_valid !== 1'b0) stray = 1'b1;
            @(posedge clk); #1;
        end
        total++; if (stray) begin bad++; $display("FAIL abort_no_ack got=1 want=0"); end
        total++; if (bus.freq !== freq_m || bus.ovf !== ovf_m) begin bad++; $display("FAIL abort_freq_hold got=%0d/%b want=%0d/%b", bus.freq, bus.ovf, freq_m, ovf_m); end
        @(negedge clk);
        cnt = rand_cnt();
        run_meas(r, cnt, 0, o);
        {ovf_m, freq_m} = hz_m(cnt);
        total++; if (int'(o.sel0) !== ch) begin bad++; $display("FAIL abort_regrant got=%0d want=%0d", o.sel0, ch); end
        total++; if ({o.ovf, o.freq} !== {ovf_m, freq_m}) begin bad++; $display("FAIL abort_next_freq got=%0d want=%0d", o.freq, freq_m); end
        ptr_m = (ch + 1) % NCH;
    endtask

    task automatic test_async_reset();
        obs_t           o;
        logic [NCH-1:0] r;
        logic [31:0]    cnt;
        int             ch;
        r = NCH'($urandom_range(1, 15));
        bus.en = 1'b1; bus.req = r;
        @(posedge clk); #1;
        repeat (6) @(posedge clk);
        @(negedge clk); #2;
        rst_b = 1'b0;
        #1;
        total++; if ({bus.meas_gate, bus.busy} !== 2'b00) begin bad++; $display("FAIL areset_gate_busy got=%b want=00", {bus.meas_gate, bus.busy}); end
        total++; if (bus.sel !== '0 || bus.freq !== '0) begin bad++; $display("FAIL areset_sel_freq got=%0d/%0d want=0/0", bus.sel, bus.freq); end
        @(negedge clk);
        rst_b = 1'b1;
        ptr_m = 0; freq_m = '0; ovf_m = 1'b0;
        ch = pick_m(r, 0);
        cnt = rand_cnt();
        run_meas(r, cnt, 0, o);
        {ovf_m, freq_m} = hz_m(cnt);
        total++; if (int'(o.sel0) !== ch || o.ack !== NCH'(1 << ch)) begin bad++; $display("FAIL areset_first_grant got=%0d/%b want=%0d", o.sel0, o.ack, ch); end
        ptr_m = (ch + 1) % NCH;
    endtask

    task automatic test_withdraw();
        obs_t o;
        bit   extra;
        run_meas(4'b0100, rand_cnt(), GATE_LEN + 2, o);
        total++; if (o.ack !== 4'b0100 || o.ack_cyc !== ACK_LAT) begin bad++; $display("FAIL withdraw_ack got=%b@%0d want=0100@%0d", o.ack, o.ack_cyc, ACK_LAT); end
        extra = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (bus.ack !== '0 || bus.busy !== 1'b0) extra = 1'b1;
        end
        total++; if (extra) begin bad++; $display("FAIL withdraw_single_pulse got=1 want=0"); end
        @(negedge clk);
        run_meas(4'hF, 32'd1, 0, o);
        total++; if (o.sel0 !== 2'd3) begin bad++; $display("FAIL withdraw_ptr got=%0d want=3", o.sel0); end
        {ovf_m, freq_m} = hz_m(32'd1);
        ptr_m = 0;
    endtask

    task automatic test_back_to_back();
        obs_t           o;
        logic [NCH-1:0] r;
        logic [31:0]    cnt;
        int             ch;
        for (int i = 0; i < 16; i++) begin
            r = NCH'($urandom_range(1, 15));
            cnt = rand_cnt();
            ch = pick_m(r, ptr_m);
            run_meas(r, cnt, 0, o);
            {ovf_m, freq_m} = hz_m(cnt);
            total++; if (o.busy0 !== 1'b1 || int'(o.sel0) !== ch) begin bad++; $display("FAIL b2b_grant[%0d] got=%b/%0d want=1/%0d", i, o.busy0, o.sel0, ch); end
            total++; if (o.ack !== NCH'(1 << ch) || o.ack_cyc !== ACK_LAT || o.fv !== 1'b1) begin
                bad++; $display("FAIL b2b_ack[%0d] got=%b@%0d want=%b@%0d", i, o.ack, o.ack_cyc, NCH'(1 << ch), ACK_LAT);
            end
            total++; if ({o.ovf, o.freq} !== {ovf_m, freq_m}) begin bad++; $display("FAIL b2b_freq[%0d] cnt=%0d got=%b/%0d want=%b/%0d", i, cnt, o.ovf, o.freq, ovf_m, freq_m); end
            total++; if (o.gate_n !== GATE_LEN || !o.sel_ok) begin bad++; $display("FAIL b2b_gate[%0d] got=%0d stable=%b want=%0d", i, o.gate_n, o.sel_ok, GATE_LEN); end
            ptr_m = (ch + 1) % NCH;
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_saturation();
        test_abort();
        test_withdraw();
        test_async_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end
endmodule
